serial_add_seq: RTL



---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Sequencer state encoding and the legal full-adder latency settings.
package serial_add_pkg;

   localparam int STATE_W     = 2;
   localparam int FA_LAT_COMB = 0;
   localparam int FA_LAT_REG  = 1;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/serial_add_seq.sv
// Bit-serial sequencer that drives a 1-bit full adder LSB first and
// assembles a WIDTH-bit sum plus final carry behind valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// ISSUE | current bit presented on fa_a/fa_b/fa_cin
// WAIT  | registered full adder settling (FA_LAT=1 only), sample here
// DONE  | result held on out_sum/out_cout until consumer takes it
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int FA_LAT = FA_LAT_REG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy
);

   localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_sr, a_nxt;
   logic [WIDTH-1:0]  b_sr, b_nxt;
   logic [WIDTH-1:0]  sum_sr, sum_nxt;
   logic              carry, carry_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [WIDTH-1:0]  res_nxt;
   logic              cout_nxt;
   logic              sample;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      a_nxt     = a_sr;
      b_nxt     = b_sr;
      sum_nxt   = sum_sr;
      carry_nxt = carry;
      idx_nxt   = idx;
      res_nxt   = out_sum;
      cout_nxt  = out_cout;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_nxt     = in_a;
               b_nxt     = in_b;
               carry_nxt = in_cin;
               sum_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (FA_LAT == FA_LAT_COMB) begin
               sample = 1'b1;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: sample = 1'b1;
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // fa_sum/fa_cout are only looked at here, so X elsewhere cannot leak in
      if (sample) begin
         sum_nxt   = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
         carry_nxt = fa_cout;
         a_nxt     = a_sr >> 1;
         b_nxt     = b_sr >> 1;
         idx_nxt   = idx + IDX_W'(1);
         if (idx == IDX_LAST) begin
            res_nxt   = sum_nxt;
            cout_nxt  = fa_cout;
            state_nxt = DONE;
         end else begin
            state_nxt = ISSUE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         fa_a     <= 1'b0;
         fa_b     <= 1'b0;
         fa_cin   <= 1'b0;
      end else begin
         a_sr     <= a_nxt;
         b_sr     <= b_nxt;
         sum_sr   <= sum_nxt;
         carry    <= carry_nxt;
         idx      <= idx_nxt;
         out_sum  <= res_nxt;
         out_cout <= cout_nxt;
         // adder inputs come straight from flops and are forced low outside ISSUE
         fa_a     <= (state_nxt == ISSUE) ? a_nxt[0] : 1'b0;
         fa_b     <= (state_nxt == ISSUE) ? b_nxt[0] : 1'b0;
         fa_cin   <= (state_nxt == ISSUE) ? carry_nxt : 1'b0;
      end
   end

endmodule
